pio_tx_fifo: RTL
================

// Module: pio_tx_fifo
// PURPOSE
//  TX FIFO between the system-bus write port and the output shift register (OSR).
//  Accepts 32-bit words from the bus and presents the head word to the OSR's fifo_in.
//  Head is first-word-fall-through. It pops when the OSR signals a PULL or an autopull.
//  Reports level, full and empty for the state machine's stall logic.
//  Keeps sticky overflow and underflow flags for debug.
// PARAMETERS
//  WIDTH  32  data word width in bits
//  DEPTH  4   entries; must be a power of 2, >= 2
//  LW     $clog2(2*DEPTH+1)  level width (localparam)
// PORTS
//  clk         in   1      clock; all state updates on posedge
//  rst         in   1      synchronous reset, active-low (0 = reset)
//  push        in   1      bus write strobe, 1 cycle per word
//  push_data   in   WIDTH  word to enqueue
//  push_ready  out  1      ~full; space available this cycle
//  pull        in   1      OSR consumed the head word this cycle (PULL or autopull)
//  fifo_out    out  WIDTH  head word, drives OSR fifo_in; 0 when empty
//  fifo_empty  out  1      level == 0
//  fifo_full   out  1      level == capacity
//  level       out  LW     words currently held, 0..capacity
//  flush       in   1      discard all contents
//  clr_flags   in   1      clear the sticky flags
//  overflow    out  1      sticky: a push was dropped
//  underflow   out  1      sticky: a pull arrived while empty
// BEHAVIOUR
//  - Reset (rst==0 at posedge) clears: wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0.
//    Outputs after reset: fifo_out=0, fifo_empty=1, fifo_full=0, push_ready=1. Memory contents are not reset.
//  - Reset mid-operation: all contents are lost at once. It has priority over every other input.
//  - Storage is a circular buffer. Pointers are $clog2(capacity) bits and wrap modulo capacity.
//  - fifo_empty, fifo_full, push_ready, level and fifo_out are combinational from registered state.
//    fifo_out = mem[rd_ptr] when level != 0, else 0.
//  - Write latency: a word pushed at edge N appears on fifo_out after edge N when the FIFO was empty.
//    No bypass within the same cycle.
//  - Push accepted = push & (~full | pull_eff). Accepted word is written to mem[wr_ptr]; wr_ptr++.
//  - pull_eff = pull & ~empty; it advances rd_ptr.
//  - level_next = level + push_accepted - pull_eff. It never exceeds capacity or goes below 0.
//  - Push and pull in the same cycle:
//      full:  both occur; level unchanged; the new word goes into the slot just freed.
//      empty: push accepted; pull ignored; underflow set; level becomes 1.
//      otherwise: both occur; level unchanged.
//  - Dropped push: push & full & ~pull. Data is discarded, overflow <= 1, no other state changes.
//  - Ignored pull: pull & empty. underflow <= 1, no other state changes.
//  - flush, when rst==1, sets both pointers and level to 0 and ignores push/pull in that cycle.
//    Sticky flags are not changed by flush.
//  - clr_flags clears both flags. If a new event occurs in the same cycle, the set wins.
// CONFIGURATION
//  PIO_TX_FIFO_JOIN_EN defined:
//    - Adds input `join` (1 bit). Storage becomes 2*DEPTH entries.
//    - Capacity = 2*DEPTH when join=1, DEPTH when join=0. Pointers wrap modulo the current capacity.
//    - Any change of `join` between consecutive cycles acts as a flush in the cycle it is seen.
//  PIO_TX_FIFO_JOIN_EN undefined:
//    - No `join` port. Storage is DEPTH entries and capacity is fixed at DEPTH.
//  LW is sized for 2*DEPTH in both builds.
// TESTING
//  1. Reset, then push 0xA0..0xA3 (DEPTH=4) -> level 1,2,3,4; full=1, push_ready=0; fifo_out=0xA0 throughout.
//  2. From full, push 0xBB with pull=0 -> overflow=1, level=4.
//     Then 4 pulls -> fifo_out reads 0xA1,0xA2,0xA3, then 0 with empty=1.
//  3. Full, push 0xCC + pull in the same cycle -> level stays 4; draining yields A1,A2,A3,CC. overflow stays 0.
//  4. Empty, push 0x55 + pull in the same cycle -> underflow=1, level=1, fifo_out=0x55.
//     Then clr_flags -> underflow=0.
//  5. Level 3, assert flush with push=1 -> level=0, empty=1, pushed word lost.
//     Assert rst=0 mid-drain -> level=0, fifo_out=0 next cycle.
//  6. JOIN_EN build, join=1: push 8 words without overflow, full at 8, wrap order preserved.
//     Toggle join -> level=0.

Source files
------------

// File: rtl/pio_tx_fifo.sv
// pio_tx_fifo: TX FIFO between the system-bus write port and the output shift
// register. The head word falls through to fifo_out and pops on a PULL or an
// autopull. The FIFO reports level/full/empty for stall logic and keeps sticky
// overflow/underflow flags for debug.
//
// Optional feature macro: PIO_TX_FIFO_JOIN_EN
//   When defined, an i_join input is added (the name `join` is a reserved word
//   in SystemVerilog, so the port carries the input prefix). Storage doubles to
//   2*DEPTH entries, and i_join selects a capacity of 2*DEPTH (1) or DEPTH (0).
//   Any change of i_join is treated as a flush in the cycle it is seen.
//   When undefined, capacity is fixed at DEPTH.

module pio_tx_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(2 * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef PIO_TX_FIFO_JOIN_EN
  input  logic             i_join,
`endif
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pull,
  output logic [WIDTH-1:0] fifo_out,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [LW-1:0]    level,
  input  logic             flush,
  input  logic             clr_flags,
  output logic             overflow,
  output logic             underflow
);

`ifdef PIO_TX_FIFO_JOIN_EN
  localparam int STORE = 2 * DEPTH;
`else
  localparam int STORE = DEPTH;
`endif
  localparam int PW = (STORE > 1) ? $clog2(STORE) : 1;

  // Storage and registered state
  logic [WIDTH-1:0] r_mem [STORE];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  // Combinational control
  logic [LW-1:0]    w_cap;        // current capacity in words
  logic [PW-1:0]    w_last;       // highest pointer value before wrap
  logic             w_flush;      // explicit flush or join-mode change
  logic             w_empty;
  logic             w_full;
  logic             w_pull_eff;
  logic             w_push_acc;
  logic             w_drop;       // push discarded because FIFO is full
  logic             w_ignored;    // pull seen while empty
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [LW-1:0]    w_level_nxt;

`ifdef PIO_TX_FIFO_JOIN_EN
  logic r_join_q;

  // Remember the join setting so a change can be recognised as a flush
  always_ff @(posedge clk) begin
    if (!rst) r_join_q <= i_join;
    else      r_join_q <= i_join;
  end

  assign w_cap   = i_join ? LW'(2 * DEPTH) : LW'(DEPTH);
  assign w_last  = i_join ? PW'(2 * DEPTH - 1) : PW'(DEPTH - 1);
  assign w_flush = flush | (i_join != r_join_q);
`else
  assign w_cap   = LW'(DEPTH);
  assign w_last  = PW'(DEPTH - 1);
  assign w_flush = flush;
`endif

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == w_cap);

  // A flush cycle ignores both push and pull, so neither flag can fire in it.
  assign w_pull_eff = pull & ~w_empty & ~w_flush;
  assign w_push_acc = push & ~w_flush & (~w_full | w_pull_eff);
  assign w_drop     = push & ~w_flush & w_full & ~pull;
  assign w_ignored  = pull & ~w_flush & w_empty;

  // Outputs are decoded from registered state only
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign push_ready = ~w_full;
  assign level      = r_level;
  assign fifo_out   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

  // Next pointer and level values, wrapping modulo the current capacity
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;

    if (w_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_level_nxt  = '0;
    end else begin
      if (w_push_acc)
        w_wr_ptr_nxt = (r_wr_ptr == w_last) ? '0 : r_wr_ptr + PW'(1);
      if (w_pull_eff)
        w_rd_ptr_nxt = (r_rd_ptr == w_last) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push_acc, w_pull_eff})
        2'b10:   w_level_nxt = r_level + LW'(1);
        2'b01:   w_level_nxt = r_level - LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Pointer and level registers; reset takes priority over every other input
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
    end
  end

  // Sticky debug flags: a new event in the same cycle beats clr_flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_drop)         r_overflow  <= 1'b1;
      else if (clr_flags) r_overflow  <= 1'b0;
      if (w_ignored)      r_underflow <= 1'b1;
      else if (clr_flags) r_underflow <= 1'b0;
    end
  end

  // Word storage; an accepted push writes the slot at the write pointer
  always_ff @(posedge clk) begin
    // NOTE: the memory has no reset. Its contents are only visible through
    // fifo_out when level is non-zero, and level is reset.
    if (w_push_acc) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
